amp_ascii_streamer: RTL and testbench
=====================================

// Module: amp_ascii_streamer
// PURPOSE
//   Sequences a binary amplitude value into a line of ASCII text for the UART
//   status path. Converts the binary value to 4-digit BCD with a sequential
//   double-dabble engine, maps each digit to ASCII ('0'..'9' = 8'h30..8'h39),
//   then streams the characters, optionally followed by CR LF, over a byte
//   valid/ready handshake. Sits between the amplitude register and the UART TX.
// PARAMETERS
//   VALUE_W        14  width of VALUE; inputs above 9999 are clamped to 9999
//   SEND_CRLF       1  1: append 8'h0D, 8'h0A after the digits; 0: digits only
//   BLANK_LEADING   0  1: leading zero digits sent as 8'h20; ones digit always sent
// PORTS
//   CLK       in   1        system clock; all state changes on rising edge
//   RESETN    in   1        asynchronous, active-low reset
//   START     in   1        request; sampled only in IDLE
//   VALUE     in   VALUE_W  unsigned amplitude; captured on the accepted START
//   TX_DATA   out  8        ASCII character
//   TX_VALID  out  1        TX_DATA is valid
//   TX_READY  in   1        sink accepts; transfer occurs when TX_VALID && TX_READY
//   BUSY      out  1        high from the cycle after START acceptance to DONE
//   DONE      out  1        one-cycle pulse after the last character transfers
//   BCD       out  16       last converted digits {thousands,hundreds,tens,ones}
// BEHAVIOUR
//   Reset: state=IDLE; TX_DATA=8'h00, TX_VALID=0, BUSY=0, DONE=0, BCD=16'h0000.
//     Reset is asynchronous in any state; an in-flight line is dropped without
//     completion and DONE is not pulsed.
//   FSM states: IDLE, CONVERT, SEND, FINISH.
//   IDLE: on START=1, capture min(VALUE,9999) and clear the shift register.
//     Next state is CONVERT, and BUSY rises on the next edge.
//   CONVERT: exactly 14 cycles. Each cycle, add 3 to every BCD nibble >= 5,
//     then shift {bcd,bin} left by 1. After cycle 14, load BCD and go to SEND.
//     No digit can exceed 9. Unused VALUE bits above 14 are covered by the clamp.
//   SEND: character index k runs 0..N-1, where N=6 if SEND_CRLF else 4.
//     k=0..3: thousands..ones, MSB first. k=4: 8'h0D. k=5: 8'h0A.
//     Blanking: digit k<3 is 8'h20 if it and all earlier digits are zero.
//     TX_VALID first asserts 15 cycles after the START cycle.
//     While TX_VALID=1 && TX_READY=0, TX_DATA and TX_VALID hold stable.
//     On each transfer, k increments and the next character is presented in the
//     next cycle, with no bubble. Transfer at k=N-1 leads to FINISH with
//     TX_VALID=0.
//   FINISH: DONE=1 and BUSY=0 for one cycle, then IDLE. A START in this cycle
//     is ignored. The earliest new START is accepted in the following cycle.
//   START asserted in CONVERT, SEND or FINISH: ignored and not queued.
//     VALUE changes after capture have no effect.
//   TX_READY held high continuously: line time = 1+14+N+1 cycles, START to DONE.
//   BCD holds its value until the next conversion completes.
// TESTING
//   1. VALUE=1234, START 1 cycle, TX_READY=1: bytes 31,32,33,34,0D,0A on
//      consecutive cycles. First TX_VALID at START+15. DONE at START+21.
//      BCD=16'h1234.
//   2. VALUE=12000: clamped, bytes 39,39,39,39,0D,0A, BCD=16'h9999.
//      VALUE=0: bytes 30,30,30,30,0D,0A.
//   3. BLANK_LEADING=1: VALUE=42 gives 20,20,34,32.
//      VALUE=0 gives 20,20,20,30. VALUE=1005 gives 31,30,30,35.
//   4. Backpressure: TX_READY toggles pseudo-randomly. Each byte is transferred
//      exactly once, in order. TX_DATA is stable while stalled.
//   5. START pulsed during CONVERT and SEND: no extra line, no change to output
//      bytes. START in the FINISH cycle is ignored. START one cycle later is
//      accepted.
//   6. RESETN low mid-SEND (k=2): outputs at reset values immediately.
//      No DONE pulse. After release, a new START for 7 gives 30,30,30,37,0D,0A.

Source files
------------

// File: rtl/amp_ascii_streamer.sv
// amp_ascii_streamer: turns a binary amplitude into a 4-digit ASCII line
// (optionally CR LF terminated) and streams it over a byte valid/ready port.
// Conversion is a sequential double-dabble, one bit per cycle.
module amp_ascii_streamer #(
    parameter int VALUE_W       = 14,
    parameter bit SEND_CRLF     = 1'b1,
    parameter bit BLANK_LEADING = 1'b0
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               START,
    input  logic [VALUE_W-1:0] VALUE,
    output logic [7:0]         TX_DATA,
    output logic               TX_VALID,
    input  logic               TX_READY,
    output logic               BUSY,
    output logic               DONE,
    output logic [15:0]        BCD
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_SEND    = 2'd2;
    localparam logic [1:0] S_FINISH  = 2'd3;

    // Compare in a width that holds both VALUE and 9999 so the clamp sees
    // every VALUE bit, whatever VALUE_W is.
    localparam int         EXT_W    = (VALUE_W > 14) ? VALUE_W : 14;
    localparam logic [3:0] LAST_CNT = 4'd13;
    localparam logic [2:0] LAST_K   = SEND_CRLF ? 3'd5 : 3'd3;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [13:0]      bin_q, bin_d;
    logic [15:0]      sh_q, sh_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [2:0]       k_q, k_d;

    logic [EXT_W-1:0] value_ext;
    logic [13:0]      clamped;
    logic [15:0]      adj;
    logic [15:0]      dabble;
    logic [7:0]       ch;
    logic             blank0, blank1, blank2;

    // Zero-extend VALUE and clamp to the largest 4-digit number.
    always_comb begin
        value_ext                = '0;
        value_ext[VALUE_W-1:0]   = VALUE;
        clamped                  = (value_ext > EXT_W'(9999)) ? 14'd9999 : value_ext[13:0];
    end

    // Double-dabble step: add 3 to every nibble >= 5, then shift in the next bit.
    always_comb begin
        adj = sh_q;
        for (int i = 0; i < 4; i++) begin
            if (sh_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = sh_q[4*i +: 4] + 4'd3;
        end
        dabble = {adj[14:0], bin_q[13]};
    end

    // Next-state logic for the sequencer and its datapath registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    bin_d   = clamped;
                    sh_d    = '0;
                    cnt_d   = '0;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                sh_d  = dabble;
                bin_d = {bin_q[12:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    bcd_d   = dabble;
                    k_d     = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (TX_READY) begin
                    if (k_q == LAST_K) state_d = S_FINISH;
                    else               k_d     = k_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset drops any line in flight.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            k_q     <= k_d;
        end
    end

    // Character for index k; a leading digit blanks only if all digits before it are zero.
    always_comb begin
        blank0 = BLANK_LEADING && (bcd_q[15:12] == 4'd0);
        blank1 = blank0 && (bcd_q[11:8] == 4'd0);
        blank2 = blank1 && (bcd_q[7:4] == 4'd0);
        ch     = 8'h00;
        case (k_q)
            3'd0:    ch = blank0 ? 8'h20 : {4'h3, bcd_q[15:12]};
            3'd1:    ch = blank1 ? 8'h20 : {4'h3, bcd_q[11:8]};
            3'd2:    ch = blank2 ? 8'h20 : {4'h3, bcd_q[7:4]};
            3'd3:    ch = {4'h3, bcd_q[3:0]};
            3'd4:    ch = 8'h0D;
            3'd5:    ch = 8'h0A;
            default: ch = 8'h00;
        endcase
    end

    // Outputs decode straight from registered state, so they are stable while stalled.
    assign TX_VALID = (state_q == S_SEND);
    assign TX_DATA  = TX_VALID ? ch : 8'h00;
    assign BUSY     = (state_q == S_CONVERT) || (state_q == S_SEND);
    assign DONE     = (state_q == S_FINISH);
    assign BCD      = bcd_q;

endmodule

// File: tb/tb_amp_ascii_streamer.sv
// Directed bench for amp_ascii_streamer: one default instance (CR LF on)
// and one with leading-zero blanking and no CR LF.
module tb_amp_ascii_streamer;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [13:0] value_a = '0, value_b = '0;
    logic        ready_a = 1'b1, ready_b = 1'b1;
    logic [7:0]  data_a, data_b;
    logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [15:0] bcd_a, bcd_b;

    int          tests_run = 0;
    int          tests_failed = 0;

    logic [7:0]  got[8];
    logic [7:0]  exp[8];
    int          n_got, t_valid, t_done;
    bit          busy1, stall_bad;

    always #5 CLK = ~CLK;

    amp_ascii_streamer dut_a (
        .CLK(CLK), .RESETN(RESETN), .START(start_a), .VALUE(value_a),
        .TX_DATA(data_a), .TX_VALID(valid_a), .TX_READY(ready_a),
        .BUSY(busy_a), .DONE(done_a), .BCD(bcd_a)
    );

    amp_ascii_streamer #(.VALUE_W(14), .SEND_CRLF(1'b0), .BLANK_LEADING(1'b1)) dut_b (
        .CLK(CLK), .RESETN(RESETN), .START(start_b), .VALUE(value_b),
        .TX_DATA(data_b), .TX_VALID(valid_b), .TX_READY(ready_b),
        .BUSY(busy_b), .DONE(done_b), .BCD(bcd_b)
    );

    // Runs one line on instance b (or a). START goes high in cycle 0; cycle
    // numbers below count from there. Extra START pulses at cycles s1..s3.
    task automatic run_line(input bit b, input logic [13:0] v, input bit bp,
                            input int s1, input int s2, input int s3);
        logic       pv, vld, rdy, st;
        logic [7:0] pd, dat;
        n_got = 0; t_valid = -1; t_done = -1; busy1 = 0; stall_bad = 0;
        pv = 0; pd = 8'h00;
        for (int i = 0; i < 8; i++) got[i] = 8'h00;
        @(negedge CLK);
        if (b) begin start_b = 1'b1; value_b = v; end
        else   begin start_a = 1'b1; value_a = v; end
        for (int c = 1; c <= 200; c++) begin
            @(negedge CLK);
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            st  = (c == s1) || (c == s2) || (c == s3);
            if (b) begin
                start_b = st; value_b = ~v; ready_b = rdy; vld = valid_b; dat = data_b;
            end else begin
                start_a = st; value_a = ~v; ready_a = rdy; vld = valid_a; dat = data_a;
            end
            if (c == 1) busy1 = b ? busy_b : busy_a;
            if (pv && !(vld && dat == pd)) stall_bad = 1;
            if (vld && t_valid < 0) t_valid = c;
            if (vld && rdy) begin
                if (n_got < 8) got[n_got] = dat;
                n_got++;
            end
            pv = vld && !rdy;
            pd = dat;
            if (b ? done_b : done_a) begin
                t_done = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        tests_run++; if (data_a !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", data_a); end
        tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
        tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        tests_run++; if (done_a !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done_a); end
        tests_run++; if (bcd_a !== 16'h0000) begin tests_failed++; $display("FAIL reset_bcd: got %h expected 0000", bcd_a); end
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        @(negedge CLK);
        tests_run++; if (busy_a !== 1'b0 || valid_a !== 1'b0) begin tests_failed++; $display("FAIL idle_after_reset: busy %b valid %b expected 0 0", busy_a, valid_a); end
    endtask

    task automatic test_basic();
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A, 8'h00, 8'h00};
        run_line(0, 14'd1234, 0, -1, -1, -1);
        tests_run++; if (n_got !== 6) begin tests_failed++; $display("FAIL basic_count: got %0d expected 6", n_got); end
        for (int i = 0; i < 6; i++) begin
            tests_run++; if (got[i] !== exp[i]) begin tests_failed++; $display("FAIL basic_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        tests_run++; if (t_valid !== 15) begin tests_failed++; $display("FAIL basic_first_valid: got %0d expected 15", t_valid); end
        tests_run++; if (t_done !== 21) begin tests_failed++; $display("FAIL basic_done_cycle: got %0d expected 21", t_done); end
        tests_run++; if (busy1 !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_rise: got %b expected 1", busy1); end
        tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_a); end
        tests_run++; if (bcd_a !== 16'h1234) begin tests_failed++; $display("FAIL basic_bcd: got %h expected 1234", bcd_a); end
    endtask

    task automatic test_clamp();
        exp = '{8'h39, 8'h39, 8'h39, 8'h39, 8'h0D, 8'h0A, 8'h00, 8'h00};
        run_line(0, 14'd12000, 0, -1, -1, -1);
        tests_run++; if (n_got !== 6) begin tests_failed++; $display("FAIL clamp_count: got %0d expected 6", n_got); end
        for (int i = 0; i < 6; i++) begin
            tests_run++; if (got[i] !== exp[i]) begin tests_failed++; $display("FAIL clamp_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        tests_run++; if (bcd_a !== 16'h9999) begin tests_failed++; $display("FAIL clamp_bcd: got %h expected 9999", bcd_a); end
        exp = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00};
        run_line(0, 14'd0, 0, -1, -1, -1);
        for (int i = 0; i < 6; i++) begin
            tests_run++; if (got[i] !== exp[i]) begin tests_failed++; $display("FAIL zero_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        tests_run++; if (bcd_a !== 16'h0000) begin tests_failed++; $display("FAIL zero_bcd: got %h expected 0000", bcd_a); end
    endtask

    task automatic test_blank();
        exp = '{8'h20, 8'h20, 8'h34, 8'h32, 8'h00, 8'h00, 8'h00, 8'h00};
        run_line(1, 14'd42, 0, -1, -1, -1);
        tests_run++; if (n_got !== 4) begin tests_failed++; $display("FAIL blank42_count: got %0d expected 4", n_got); end
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (got[i] !== exp[i]) begin tests_failed++; $display("FAIL blank42_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        tests_run++; if (t_done !== 19) begin tests_failed++; $display("FAIL blank42_done_cycle: got %0d expected 19", t_done); end
        exp = '{8'h20, 8'h20, 8'h20, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00};
        run_line(1, 14'd0, 0, -1, -1, -1);
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (got[i] !== exp[i]) begin tests_failed++; $display("FAIL blank0_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        exp = '{8'h31, 8'h30, 8'h30, 8'h35, 8'h00, 8'h00, 8'h00, 8'h00};
        run_line(1, 14'd1005, 0, -1, -1, -1);
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (got[i] !== exp[i]) begin tests_failed++; $display("FAIL blank1005_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        tests_run++; if (bcd_b !== 16'h1005) begin tests_failed++; $display("FAIL blank1005_bcd: got %h expected 1005", bcd_b); end
    endtask

    task automatic test_backpressure();
        exp = '{8'h39, 8'h30, 8'h35, 8'h32, 8'h0D, 8'h0A, 8'h00, 8'h00};
        run_line(0, 14'd9052, 1, -1, -1, -1);
        ready_a = 1'b1;
        tests_run++; if (n_got !== 6) begin tests_failed++; $display("FAIL bp_count: got %0d expected 6", n_got); end
        for (int i = 0; i < 6; i++) begin
            tests_run++; if (got[i] !== exp[i]) begin tests_failed++; $display("FAIL bp_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        tests_run++; if (stall_bad !== 1'b0) begin tests_failed++; $display("FAIL bp_stall_stable: got %b expected 0", stall_bad); end
        tests_run++; if (t_done < 21) begin tests_failed++; $display("FAIL bp_done_cycle: got %0d expected >= 21", t_done); end
    endtask

    task automatic test_start_ignored();
        int n, nv;
        bit seen;
        exp = '{8'h30, 8'h33, 8'h30, 8'h35, 8'h0D, 8'h0A, 8'h00, 8'h00};
        // START during CONVERT (5), SEND (17) and in the FINISH cycle (21)
        run_line(0, 14'd305, 0, 5, 17, 21);
        for (int i = 0; i < 6; i++) begin
            tests_run++; if (got[i] !== exp[i]) begin tests_failed++; $display("FAIL ign_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        tests_run++; if (t_done !== 21) begin tests_failed++; $display("FAIL ign_done_cycle: got %0d expected 21", t_done); end
        // START is still high into the next cycle: that one must be taken.
        @(negedge CLK);
        value_a = 14'd88;
        tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL ign_finish_start: busy %b expected 0", busy_a); end
        @(negedge CLK);
        start_a = 1'b0;
        value_a = 14'd0;
        tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL ign_next_start: busy %b expected 1", busy_a); end
        exp = '{8'h30, 8'h30, 8'h38, 8'h38, 8'h0D, 8'h0A, 8'h00, 8'h00};
        n = 0; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge CLK);
            if (valid_a && ready_a) begin
                if (n < 8) got[n] = data_a;
                n++;
            end
            if (done_a) seen = 1;
        end
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL ign_restart_done: got no DONE expected DONE within 40 cycles"); end
        tests_run++; if (n !== 6) begin tests_failed++; $display("FAIL ign_restart_count: got %0d expected 6", n); end
        for (int i = 0; i < 6; i++) begin
            tests_run++; if (got[i] !== exp[i]) begin tests_failed++; $display("FAIL ign_restart_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        nv = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge CLK);
            if (valid_a || busy_a) nv++;
        end
        tests_run++; if (nv !== 0) begin tests_failed++; $display("FAIL ign_no_extra_line: got %0d active cycles expected 0", nv); end
    endtask

    task automatic test_reset_midsend();
        int nd;
        @(negedge CLK);
        start_a = 1'b1; value_a = 14'd5678; ready_a = 1'b1;
        @(negedge CLK);
        start_a = 1'b0;
        repeat (16) @(negedge CLK);
        // cycle 17: third character on the wire
        tests_run++; if (valid_a !== 1'b1 || data_a !== 8'h37) begin tests_failed++; $display("FAIL rst_k2: valid %b data %h expected 1 37", valid_a, data_a); end
        #2 RESETN = 1'b0;
        #1;
        tests_run++; if (data_a !== 8'h00 || valid_a !== 1'b0) begin tests_failed++; $display("FAIL rst_async_tx: data %h valid %b expected 00 0", data_a, valid_a); end
        tests_run++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin tests_failed++; $display("FAIL rst_async_flags: busy %b done %b expected 0 0", busy_a, done_a); end
        tests_run++; if (bcd_a !== 16'h0000) begin tests_failed++; $display("FAIL rst_async_bcd: got %h expected 0000", bcd_a); end
        nd = 0;
        repeat (3) begin
            @(negedge CLK);
            if (done_a) nd++;
        end
        RESETN = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (done_a) nd++;
        end
        tests_run++; if (nd !== 0) begin tests_failed++; $display("FAIL rst_no_done: got %0d DONE cycles expected 0", nd); end
        exp = '{8'h30, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A, 8'h00, 8'h00};
        run_line(0, 14'd7, 0, -1, -1, -1);
        tests_run++; if (n_got !== 6) begin tests_failed++; $display("FAIL rst_after_count: got %0d expected 6", n_got); end
        for (int i = 0; i < 6; i++) begin
            tests_run++; if (got[i] !== exp[i]) begin tests_failed++; $display("FAIL rst_after_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_blank();
        test_backpressure();
        test_start_ignored();
        test_reset_midsend();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
